// File: rtl/uart_rx_fifo.sv
// Console UART receiver: 8N1 deframer (8E1 when UART_RX_PARITY_EN is defined)
// feeding a show-ahead byte FIFO with sticky overflow and pulsed error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_raw,
    input  logic       rd_en,
    input  logic       clr_ovrflw,
    output logic [7:0] rx_data_out,
    output logic       d_valid,
    output logic       overflow,
    output logic       sfe,
    output logic       pe
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic          rx_meta_q;
    logic          rxs_q;
    logic [1:0]    flush_q;
    logic          armed_q;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          sfe_q, sfe_d;
    logic          push_req;

`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          pe_q, pe_d;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, push;

    // armed_q waits for a genuine high on the line after reset, so a line
    // already low at release is not mistaken for a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            flush_q   <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_raw;
            rxs_q     <= rx_meta_q;
            flush_q   <= {flush_q[0], 1'b1};
            if (flush_q[1] && rxs_q) armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        sfe_d    = 1'b0;
        push_req = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        pe_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (armed_q && !rxs_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_CNT;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = BIT_CNT;
                    bit_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = BIT_CNT;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d   = BIT_CNT;
                    state_d = S_STOP;
                    if (^{shift_q, rxs_q}) begin
                        par_bad_d = 1'b1;
                        pe_d      = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs_q) begin
                    state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    push_req = !par_bad_q;
`else
                    push_req = 1'b1;
`endif
                end else begin
                    state_d = S_WAIT_IDLE;
                    sfe_d   = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            sfe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sfe_q   <= sfe_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            pe_q      <= pe_d;
        end
    end
    assign pe = pe_q;
`else
    assign pe = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is accepted when rd_en drains the head.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = rd_en && !empty;
    assign push  = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (clr_ovrflw) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    assign rx_data_out = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign d_valid     = !empty;
    assign overflow    = ovf_q;
    assign sfe         = sfe_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=8.
// Parity scenarios run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

    localparam int C = 16;
    localparam int D = 8;
    // Line low before edge 1, sync flops at edges 1-2, FSM leaves IDLE at edge 3,
    // then C/2 to mid start plus one bit time per data/parity/stop bit.
`ifdef UART_RX_PARITY_EN
    localparam int PUSH = 3 + C / 2 + 10 * C;
`else
    localparam int PUSH = 3 + C / 2 + 9 * C;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_raw = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_ovrflw = 1'b0;
    logic [7:0] rx_data_out;
    logic       d_valid;
    logic       overflow;
    logic       sfe;
    logic       pe;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   sfe_hi = 0;
    int   pe_hi = 0;
    logic dv_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_raw     (rx_raw),
        .rd_en      (rd_en),
        .clr_ovrflw (clr_ovrflw),
        .rx_data_out(rx_data_out),
        .d_valid    (d_valid),
        .overflow   (overflow),
        .sfe        (sfe),
        .pe         (pe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sfe) sfe_hi++;
        if (pe) pe_hi++;
        if (d_valid && !dv_prev) rise_cyc = cyc;
        dv_prev = d_valid;
    end

    // Drives a frame up to the negedge just before the push edge.
    task automatic frame_head(input logic [7:0] b);
        int n;
        rx_raw = 1'b0;
        repeat (C) @(negedge clk);
        n = C;
        for (int i = 0; i < 8; i++) begin
            rx_raw = b[i];
            repeat (C) @(negedge clk);
            n += C;
        end
`ifdef UART_RX_PARITY_EN
        rx_raw = (^b) ^ par_flip;
        repeat (C) @(negedge clk);
        n += C;
`endif
        rx_raw = 1'b1;
        repeat (PUSH - 1 - n) @(negedge clk);
    endtask

    task automatic frame_tail();
        repeat (2 * C) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        frame_head(b);
        @(negedge clk);
        frame_tail();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rst_dvalid got %b want 0", d_valid); end
        n_cmp++; if (rx_data_out !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", rx_data_out); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
        n_cmp++; if (sfe !== 1'b0) begin n_err++; $display("FAIL rst_sfe got %b want 0", sfe); end
        n_cmp++; if (pe !== 1'b0) begin n_err++; $display("FAIL rst_pe got %b want 0", pe); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int s0;
        s0 = cyc;
        frame_head(8'hA5);
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL basic_early got %b want 0", d_valid); end
        @(negedge clk);
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL basic_dvalid got %b want 1", d_valid); end
        n_cmp++; if (rx_data_out !== 8'hA5) begin n_err++; $display("FAIL basic_data got %h want a5", rx_data_out); end
        frame_tail();
        n_cmp++; if (rise_cyc - s0 !== PUSH) begin n_err++; $display("FAIL basic_latency got %0d want %0d", rise_cyc - s0, PUSH); end
        pop_one();
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL basic_pop_dv got %b want 0", d_valid); end
        n_cmp++; if (rx_data_out !== 8'h00) begin n_err++; $display("FAIL basic_pop_data got %h want 00", rx_data_out); end
        pop_one();
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL empty_pop_dv got %b want 0", d_valid); end
    endtask

    task automatic test_glitch();
        sfe_hi = 0;
        rx_raw = 1'b0;
        repeat (5) @(negedge clk);
        rx_raw = 1'b1;
        repeat (2 * C) @(negedge clk);
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL glitch_dv got %b want 0", d_valid); end
        n_cmp++; if (sfe_hi !== 0) begin n_err++; $display("FAIL glitch_sfe got %0d want 0", sfe_hi); end
        send_byte(8'h5A);
        n_cmp++; if (rx_data_out !== 8'h5A) begin n_err++; $display("FAIL glitch_after got %h want 5a", rx_data_out); end
        pop_one();
    endtask

    task automatic test_framing();
        logic [7:0] b;
        b = 8'h3C;
        sfe_hi = 0;
        rx_raw = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_raw = b[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_raw = ^b;
        repeat (C) @(negedge clk);
`endif
        rx_raw = 1'b0;
        repeat (3 * C) @(negedge clk);
        rx_raw = 1'b1;
        repeat (2 * C) @(negedge clk);
        n_cmp++; if (sfe_hi !== 1) begin n_err++; $display("FAIL sfe_pulse got %0d want 1", sfe_hi); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL sfe_dv got %b want 0", d_valid); end
        send_byte(8'h11);
        n_cmp++; if (rx_data_out !== 8'h11) begin n_err++; $display("FAIL sfe_after got %h want 11", rx_data_out); end
        pop_one();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) send_byte(8'(i));
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rx_data_out !== 8'(i)) begin n_err++; $display("FAIL ovf_read%0d got %h want %h", i, rx_data_out, 8'(i)); end
            pop_one();
        end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain got %b want 0", d_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        clr_ovrflw = 1'b1;
        @(negedge clk);
        clr_ovrflw = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b want 0", overflow); end
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i));
        frame_head(8'h28);
        clr_ovrflw = 1'b1;
        @(negedge clk);
        clr_ovrflw = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_prio got %b want 1", overflow); end
        @(negedge clk);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_prio_hold got %b want 1", overflow); end
        frame_tail();
        n_cmp++; if (rx_data_out !== 8'h20) begin n_err++; $display("FAIL ovf_head got %h want 20", rx_data_out); end
        for (int i = 0; i < 8; i++) pop_one();
        clr_ovrflw = 1'b1;
        @(negedge clk);
        clr_ovrflw = 1'b0;
    endtask

    task automatic test_pop_on_push();
        logic [7:0] e;
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i));
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_pre_ovf got %b want 0", overflow); end
        frame_head(8'h55);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf got %b want 0", overflow); end
        frame_tail();
        for (int i = 0; i < 8; i++) begin
            e = (i < 7) ? 8'h41 + 8'(i) : 8'h55;
            n_cmp++; if (rx_data_out !== e) begin n_err++; $display("FAIL pp_read%0d got %h want %h", i, rx_data_out, e); end
            pop_one();
        end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL pp_drain got %b want 0", d_valid); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        pe_hi = 0;
        par_flip = 1'b1;
        send_byte(8'h01);
        par_flip = 1'b0;
        n_cmp++; if (pe_hi !== 1) begin n_err++; $display("FAIL pe_pulse got %0d want 1", pe_hi); end
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL pe_dv got %b want 0", d_valid); end
        send_byte(8'h01);
        n_cmp++; if (rx_data_out !== 8'h01) begin n_err++; $display("FAIL pe_good got %h want 01", rx_data_out); end
        pop_one();
        pe_hi = 0;
    endtask
`endif

    task automatic test_rst_midframe();
        send_byte(8'h99);
        sfe_hi = 0;
        rx_raw = 1'b0;
        repeat (3 * C) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL mrst_dv got %b want 0", d_valid); end
        n_cmp++; if (rx_data_out !== 8'h00) begin n_err++; $display("FAIL mrst_data got %h want 00", rx_data_out); end
        rst = 1'b0;
        repeat (2 * C) @(negedge clk);
        rx_raw = 1'b1;
        repeat (12 * C) @(negedge clk);
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL mrst_nostart got %b want 0", d_valid); end
        n_cmp++; if (sfe_hi !== 0) begin n_err++; $display("FAIL mrst_sfe got %0d want 0", sfe_hi); end
        send_byte(8'h7E);
        n_cmp++; if (rx_data_out !== 8'h7E) begin n_err++; $display("FAIL mrst_resume got %h want 7e", rx_data_out); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overflow();
        test_pop_on_push();
`ifdef UART_RX_PARITY_EN
        test_parity();
`else
        n_cmp++; if (pe_hi !== 0) begin n_err++; $display("FAIL pe_tied got %0d want 0", pe_hi); end
`endif
        test_rst_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
